// File: rtl/log_arb_pkg.sv
// rtl/log_arb_pkg.sv - shared types, widths and helpers for log_arbiter
package log_arb_pkg;

   // width of the per-channel statistics counters
   localparam int CNT_W = 16;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } arb_state_e;

   // channel ID width, never narrower than one bit
   function automatic int ch_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/log_tag_fifo.sv
// rtl/log_tag_fifo.sv - in-order channel tag queue for words in flight
module log_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // storage write and pointer advance; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // occupancy: simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (do_push && !do_pop) begin
         count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/log_arbiter.sv
// rtl/log_arbiter.sv - round-robin sharing of one log engine; optional stats via LOG_ARB_STATS_EN
module log_arbiter
   import log_arb_pkg::*;
#(
   parameter  int N_CH      = 4,
   parameter  int DATA_W    = 32,
   parameter  int LOG_W     = 16,
   parameter  int TAG_DEPTH = 8,
   localparam int CH_W      = ch_width(N_CH)
) (
   input  logic                   clk_in,
   input  logic                   rst_n_in,
   input  logic [N_CH*DATA_W-1:0] ch_data_in,
   input  logic [N_CH-1:0]        ch_valid_in,
   output logic [N_CH-1:0]        ch_ready_out,
   output logic [DATA_W-1:0]      log_data_out,
   output logic                   log_valid_out,
   input  logic                   log_ready_in,
   input  logic [LOG_W-1:0]       res_data_in,
   input  logic                   res_valid_in,
   output logic                   res_ready_out,
   output logic [LOG_W-1:0]       out_data_out,
   output logic [CH_W-1:0]        out_ch_out,
   output logic                   out_valid_out,
   input  logic                   out_ready_in,
   input  logic                   flush_in,
   output logic                   flush_done_out,
`ifdef LOG_ARB_STATS_EN
   output logic [N_CH*CNT_W-1:0]  grant_cnt_out,
   output logic [CNT_W-1:0]       stall_cnt_out,
`endif
   output logic                   err_orphan_out
);

   localparam logic [CH_W:0]   N_CH_W   = (CH_W + 1)'(N_CH);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

   arb_state_e      state;
   logic [CH_W-1:0] rr_ptr;
   logic [CH_W-1:0] grant_idx;
   logic            grant_any;
   logic [CH_W:0]   cand_sum;
   logic [CH_W-1:0] cand_idx;
   logic            load_ok;
   logic            ch_hs;
   logic [CH_W-1:0] fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;

   // the slot may take a new word when running, a tag entry is free and the slot is empty or draining
   assign load_ok  = (state == RUN) && !fifo_full && (!log_valid_out || log_ready_in);
   assign ch_hs    = grant_any && load_ok;
   assign fifo_pop = !fifo_empty && res_valid_in && out_ready_in;

   // round-robin search for the first valid channel starting at rr_ptr
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_sum  = '0;
      cand_idx  = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand_sum = {1'b0, rr_ptr} + (CH_W + 1)'(k);
         if (cand_sum >= N_CH_W) begin
            cand_sum = cand_sum - N_CH_W;
         end
         cand_idx = cand_sum[CH_W-1:0];
         if (!grant_any && ch_valid_in[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // ready goes only to the granted channel, and only when the slot can load
   always_comb begin
      ch_ready_out = '0;
      if (ch_hs) begin
         ch_ready_out[grant_idx] = 1'b1;
      end
   end

   // issue slot: hold while the engine stalls, clear on handshake with no replacement
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         log_valid_out <= 1'b0;
         log_data_out  <= '0;
      end else if (ch_hs) begin
         log_valid_out <= 1'b1;
         log_data_out  <= ch_data_in[grant_idx*DATA_W +: DATA_W];
      end else if (log_ready_in) begin
         log_valid_out <= 1'b0;
      end
   end

   // rotate priority past the channel just served
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rr_ptr <= '0;
      end else if (ch_hs) begin
         rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
   end

   log_tag_fifo #(
      .WIDTH (CH_W),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .push      (ch_hs),
      .push_data (grant_idx),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // result pass-through tagged with the oldest queued channel; untagged results are sunk
   always_comb begin
      out_valid_out = 1'b0;
      out_data_out  = '0;
      out_ch_out    = '0;
      res_ready_out = 1'b1;
      if (!fifo_empty) begin
         out_valid_out = res_valid_in;
         out_data_out  = res_data_in;
         out_ch_out    = fifo_head;
         res_ready_out = out_ready_in;
      end
   end

   // sticky flag for a result that had no tag to pair with
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         err_orphan_out <= 1'b0;
      end else if (fifo_empty && res_valid_in) begin
         err_orphan_out <= 1'b1;
      end
   end

   // flush FSM: stop granting, wait for slot and tags to empty, then pulse done
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= RUN;
         flush_done_out <= 1'b0;
      end else begin
         flush_done_out <= 1'b0;
         case (state)
            RUN: begin
               if (flush_in) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!log_valid_out && fifo_empty) begin
                  state          <= RUN;
                  flush_done_out <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef LOG_ARB_STATS_EN
   // accepted words per channel and engine back-pressure cycles, both wrapping
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         grant_cnt_out <= '0;
         stall_cnt_out <= '0;
      end else begin
         if (ch_hs) begin
            grant_cnt_out[grant_idx*CNT_W +: CNT_W] <= grant_cnt_out[grant_idx*CNT_W +: CNT_W] + 1'b1;
         end
         if (log_valid_out && !log_ready_in) begin
            stall_cnt_out <= stall_cnt_out + 1'b1;
         end
      end
   end
`else
   // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_log_arbiter.sv
// tb/tb_log_arbiter.sv - randomized self-checking bench for log_arbiter against a queue-based model
module tb_log_arbiter;
   import log_arb_pkg::*;

   localparam int N_CH      = 4;
   localparam int DATA_W    = 32;
   localparam int LOG_W     = 16;
   localparam int TAG_DEPTH = 8;
   localparam int CH_W      = 2;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_CH*DATA_W-1:0] ch_data;
   logic [N_CH-1:0]        ch_valid;
   logic [N_CH-1:0]        ch_ready;
   logic [DATA_W-1:0]      log_data;
   logic                   log_valid;
   logic                   log_ready;
   logic [LOG_W-1:0]       res_data;
   logic                   res_valid;
   logic                   res_ready;
   logic [LOG_W-1:0]       out_data;
   logic [CH_W-1:0]        out_ch;
   logic                   out_valid;
   logic                   out_ready;
   logic                   flush;
   logic                   flush_done;
   logic                   err_orphan;
`ifdef LOG_ARB_STATS_EN
   logic [N_CH*CNT_W-1:0]  grant_cnt;
   logic [CNT_W-1:0]       stall_cnt;
`endif

   always #5 clk = ~clk;

   log_arbiter #(
      .N_CH      (N_CH),
      .DATA_W    (DATA_W),
      .LOG_W     (LOG_W),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .ch_data_in     (ch_data),
      .ch_valid_in    (ch_valid),
      .ch_ready_out   (ch_ready),
      .log_data_out   (log_data),
      .log_valid_out  (log_valid),
      .log_ready_in   (log_ready),
      .res_data_in    (res_data),
      .res_valid_in   (res_valid),
      .res_ready_out  (res_ready),
      .out_data_out   (out_data),
      .out_ch_out     (out_ch),
      .out_valid_out  (out_valid),
      .out_ready_in   (out_ready),
      .flush_in       (flush),
      .flush_done_out (flush_done),
`ifdef LOG_ARB_STATS_EN
      .grant_cnt_out  (grant_cnt),
      .stall_cnt_out  (stall_cnt),
`endif
      .err_orphan_out (err_orphan)
   );

   // reference model: words in flight as a queue of channel IDs plus a one-word slot
   int          tagq[$];
   bit          m_run;
   int          m_rr;
   bit          m_slot_v;
   logic [31:0] m_slot_d;
   bit          m_done;
   bit          m_err;
   logic [15:0] m_gcnt [N_CH];
   logic [15:0] m_stall;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_seen = 0;
   int done_seen = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      tagq.delete();
      m_run    = 1'b1;
      m_rr     = 0;
      m_slot_v = 1'b0;
      m_slot_d = '0;
      m_done   = 1'b0;
      m_err    = 1'b0;
      m_stall  = '0;
      for (int c = 0; c < N_CH; c++) m_gcnt[c] = '0;
   endtask

   task automatic set_idle();
      ch_valid  = '0;
      ch_data   = '0;
      res_valid = 1'b0;
      res_data  = '0;
      log_ready = 1'b1;
      out_ready = 1'b1;
      flush     = 1'b0;
   endtask

   // one clock: compare at the falling edge, advance the model, return just after the rising edge
   task automatic step();
      bit             found;
      bit             lok;
      bit             hs;
      bit             pop;
      int             g;
      logic [N_CH-1:0] e_ready;
      @(negedge clk);
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N_CH; k++) begin
         int c;
         c = (m_rr + k) % N_CH;
         if (!found && ch_valid[CH_W'(c)]) begin
            found = 1'b1;
            g     = c;
         end
      end
      lok     = m_run && (tagq.size() < TAG_DEPTH) && (!m_slot_v || log_ready);
      hs      = lok && found;
      e_ready = hs ? N_CH'(1 << g) : '0;
      check("ch_ready", ch_ready, e_ready);
      check("log_valid", log_valid, m_slot_v);
      check("log_data", log_data, m_slot_d);
      if (tagq.size() > 0) begin
         check("out_valid", out_valid, res_valid);
         check("out_data", out_data, res_data);
         check("out_ch", out_ch, tagq[0]);
         check("res_ready", res_ready, out_ready);
      end else begin
         check("out_valid_empty", out_valid, 0);
         check("res_ready_empty", res_ready, 1);
      end
      check("flush_done", flush_done, m_done);
      check("err_orphan", err_orphan, m_err);
`ifdef LOG_ARB_STATS_EN
      for (int c = 0; c < N_CH; c++) check("grant_cnt", grant_cnt[c*CNT_W +: CNT_W], m_gcnt[c]);
      check("stall_cnt", stall_cnt, m_stall);
`endif
      if ((ch_ready & ch_valid) != '0) hs_seen++;
      if (flush_done) done_seen++;
      pop = (tagq.size() > 0) && res_valid && out_ready;
      if (tagq.size() == 0 && res_valid) m_err = 1'b1;
      m_done = 1'b0;
      if (m_run) begin
         if (flush) m_run = 1'b0;
      end else if (!m_slot_v && tagq.size() == 0) begin
         m_run  = 1'b1;
         m_done = 1'b1;
      end
      if (m_slot_v && !log_ready) m_stall = m_stall + 16'd1;
      if (pop) void'(tagq.pop_front());
      if (hs) begin
         tagq.push_back(g);
         m_slot_v = 1'b1;
         m_slot_d = ch_data[g*DATA_W +: DATA_W];
         m_rr     = (g + 1) % N_CH;
         m_gcnt[g] = m_gcnt[g] + 16'd1;
      end else if (log_ready) begin
         m_slot_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // asynchronous reset mid-cycle with a result still offered; everything must clear at once
   task automatic do_reset();
      ch_valid  = '0;
      flush     = 1'b0;
      res_valid = 1'b1;
      res_data  = 16'h5a5a;
      #2 rst_n = 1'b0;
      #1;
      check("rst_log_valid", log_valid, 0);
      check("rst_log_data", log_data, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_res_ready", res_ready, 1);
      check("rst_ch_ready", ch_ready, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_err", err_orphan, 0);
`ifdef LOG_ARB_STATS_EN
      check("rst_grant_cnt", grant_cnt, 0);
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      model_reset();
      set_idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_data();
      ch_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      logic [15:0] stall0;
      rst_n = 1'b1;
      set_idle();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // all channels valid, engine and output always ready
      for (int c = 0; c < N_CH; c++) ch_data[c*DATA_W +: DATA_W] = 32'(16 * (c + 1));
      ch_valid = '1;
      hs_seen  = 0;
      repeat (40) begin
         res_valid = (tagq.size() > 0);
         res_data  = 16'($urandom);
         step();
      end
      check("full_rate_grants", hs_seen, 40);

      // a single requester is served every cycle
      do_reset();
      ch_valid = 4'b0100;
      hs_seen  = 0;
      repeat (20) begin
         rand_data();
         res_valid = (tagq.size() > 0);
         res_data  = 16'($urandom);
         step();
      end
      check("single_ch_grants", hs_seen, 20);

      // engine stall holds the slot word
      do_reset();
      ch_valid = 4'b0010;
      ch_data[1*DATA_W +: DATA_W] = 32'h1234;
      step();
      ch_valid  = '1;
      log_ready = 1'b0;
`ifdef LOG_ARB_STATS_EN
      stall0 = stall_cnt;
`else
      stall0 = '0;
`endif
      repeat (5) step();
`ifdef LOG_ARB_STATS_EN
      check("stall_plus5", stall_cnt, stall0 + 16'd5);
`endif
      log_ready = 1'b1;
      repeat (3) step();

      // no results: the tag queue limits words in flight
      do_reset();
      rand_data();
      ch_valid = '1;
      hs_seen  = 0;
      repeat (15) step();
      check("inflight_limit", hs_seen, TAG_DEPTH);
      res_valid = 1'b1;
      res_data  = 16'h0777;
      step();
      res_valid = 1'b0;
      repeat (3) step();

      // flush with three words in flight
      do_reset();
      ch_valid = 4'b0001;
      repeat (3) begin rand_data(); step(); end
      ch_valid = '0;
      flush    = 1'b1;
      step();
      flush     = 1'b0;
      ch_valid  = '1;
      res_valid = 1'b1;
      done_seen = 0;
      repeat (8) begin res_data = 16'($urandom); step(); end
      check("flush_done_count", done_seen, 1);

      // orphan results, then reset in the middle of traffic
      do_reset();
      res_valid = 1'b1;
      repeat (3) begin res_data = 16'($urandom); step(); end
      repeat (20) begin
         rand_data();
         ch_valid  = N_CH'($urandom);
         log_ready = ($urandom_range(0, 3) != 0);
         res_valid = $urandom_range(0, 1);
         res_data  = 16'($urandom);
         step();
      end
      do_reset();

      // free-running random traffic with occasional flushes
      repeat (600) begin
         rand_data();
         ch_valid  = N_CH'($urandom);
         log_ready = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         res_valid = (tagq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
         res_data  = 16'($urandom);
         flush     = ($urandom_range(0, 19) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
